// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the program counter, presents the instruction memory address, applies
// writeback/execute redirects and hazard-unit stall/flush requests, and drives
// the decode-stage instruction bus with its PC values.
//
// Ports:
//   clk, reset            core clock; asynchronous active-high reset
//   StallF, StallD, FlushD hazard-unit controls
//   BranchTakenE/ALUResultE execute-stage redirect and target
//   PCSrcW/ResultW        writeback-stage PC write and target
//   imem_addr (out)       instruction address, equal to PCF
//   imem_rdata/imem_ready instruction word and its valid strobe
//   PCF                   current fetch PC
//   InstrD/ValidD/PCD     IF/ID register contents
//   PCPlus8D              PCD + 8 (R15 read value), combinational
//   fetch_cnt/stall_cnt/flush_cnt  performance counters, present only when
//                         the macro FETCH_PERF_CNT_EN is defined
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic        ValidD,
    output logic [31:0] PCD,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [31:0] PCPlus8D
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;
    logic [XLEN-1:0] r_pcd;

    logic            w_redirect;
    logic [XLEN-1:0] w_pc_next;
    logic            w_ifid_bubble;
    logic            w_ifid_load;

    // Next-PC selection: writeback redirect beats execute redirect, and any
    // redirect overrides both StallF and a not-ready instruction memory.
    always_comb begin
        w_redirect = PCSrcW | BranchTakenE;
        w_pc_next  = r_pc + XLEN'(4);
        if (PCSrcW) begin
            w_pc_next = ResultW;
        end else if (BranchTakenE) begin
            w_pc_next = ALUResultE;
        end else if (StallF || !imem_ready) begin
            w_pc_next = r_pc;
        end
    end

    // IF/ID load decision: FlushD beats StallD; a wrong-path word fetched in a
    // redirect cycle and a cycle with no memory data both become bubbles.
    always_comb begin
        w_ifid_bubble = FlushD | (!StallD & (w_redirect | !imem_ready));
        w_ifid_load   = !FlushD & !StallD & !w_redirect & imem_ready;
    end

    // Program counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID pipeline register; a bubble also clears the PC field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
            r_pcd   <= '0;
        end else if (w_ifid_bubble) begin
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
            r_pcd   <= '0;
        end else if (w_ifid_load) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_pcd   <= r_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_fetch_cnt;
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;
    logic            w_stall_evt;
    logic            w_flush_evt;

    // A hold counts as a stall only when no redirect moved the PC; a flush
    // event is any bubble caused by FlushD or by a redirect.
    always_comb begin
        w_stall_evt = !w_redirect & (StallF | !imem_ready);
        w_flush_evt = FlushD | (!StallD & w_redirect);
    end

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_ifid_load) r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
            if (w_stall_evt) r_stall_cnt <= r_stall_cnt + XLEN'(1);
            if (w_flush_evt) r_flush_cnt <= r_flush_cnt + XLEN'(1);
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    assign PCF       = r_pc;
    assign imem_addr = r_pc;
    assign InstrD    = r_instr;
    assign ValidD    = r_valid;
    assign PCD       = r_pcd;
    assign PCPlus8D  = r_pcd + XLEN'(8);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// hazard/redirect traffic checked against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] BUB = 32'hE1A0_0000;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic [31:0] PCF, InstrD, PCD, PCPlus8D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

    int vectors;
    int miscompares;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_pcd;
    logic        m_valid;
    logic [31:0] m_fetch, m_stall, m_flush;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUBBLE_INSTR(BUB)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .PCF(PCF), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .PCPlus8D(PCPlus8D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: a scrambled function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic idle_inputs();
        StallF = 0; StallD = 0; FlushD = 0;
        BranchTakenE = 0; PCSrcW = 0;
        ALUResultE = 0; ResultW = 0;
        imem_ready = 1;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = BUB; m_valid = 0; m_pcd = 0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    // One clock edge of the architectural rules, using current inputs.
    task automatic model_step();
        logic redir;
        redir = PCSrcW || BranchTakenE;
        if (FlushD || (!StallD && (redir || !imem_ready))) begin
            if (FlushD || redir) m_flush = m_flush + 1;
            m_instr = BUB; m_valid = 0; m_pcd = 0;
        end else if (!StallD) begin
            m_instr = mem_word(m_pc); m_valid = 1; m_pcd = m_pc;
            m_fetch = m_fetch + 1;
        end
        if (PCSrcW)            m_pc = ResultW;
        else if (BranchTakenE) m_pc = ALUResultE;
        else if (StallF || !imem_ready) m_stall = m_stall + 1;
        else                   m_pc = m_pc + 4;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #1;
        vectors++;
        if ({PCF, InstrD, ValidD, PCD, PCPlus8D, imem_addr} !==
            {32'h0, BUB, 1'b0, 32'h0, 32'h8, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_values: got pc=%h instr=%h v=%b pcd=%h p8=%h addr=%h want 0/%h/0/0/8/0",
                     PCF, InstrD, ValidD, PCD, PCPlus8D, imem_addr, BUB);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_counters: got %h %h %h want 0", fetch_cnt, stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (PCF !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL seq_pc[%0d]: got %h want %h", i, PCF, 32'(4 * i));
            end
            cycle();
        end
        vectors++;
        if ({InstrD, ValidD, PCD, PCPlus8D, PCF} !== {mem_word(32'd12), 1'b1, 32'd12, 32'd20, 32'd16}) begin
            miscompares++;
            $display("FAIL seq_decode: got instr=%h v=%b pcd=%h p8=%h pc=%h want %h/1/c/14/10",
                     InstrD, ValidD, PCD, PCPlus8D, PCF, mem_word(32'd12));
        end
    endtask

    task automatic test_branch();
        do_reset();
        cycle(); cycle();
        BranchTakenE = 1; ALUResultE = 32'h100;
        cycle();
        BranchTakenE = 0;
        vectors++;
        if ({PCF, ValidD, InstrD} !== {32'h100, 1'b0, BUB}) begin
            miscompares++;
            $display("FAIL branch_redirect: got pc=%h v=%b instr=%h want 100/0/%h", PCF, ValidD, InstrD, BUB);
        end
        cycle();
        vectors++;
        if ({PCD, ValidD, InstrD, PCF} !== {32'h100, 1'b1, mem_word(32'h100), 32'h104}) begin
            miscompares++;
            $display("FAIL branch_target_decode: got pcd=%h v=%b instr=%h pc=%h want 100/1/%h/104",
                     PCD, ValidD, InstrD, PCF, mem_word(32'h100));
        end
    endtask

    task automatic test_wb_priority();
        do_reset();
        cycle();
        PCSrcW = 1; ResultW = 32'h40; BranchTakenE = 1; ALUResultE = 32'h80;
        cycle();
        vectors++;
        if ({PCF, ValidD, InstrD} !== {32'h40, 1'b0, BUB}) begin
            miscompares++;
            $display("FAIL wb_over_branch: got pc=%h v=%b instr=%h want 40/0/%h", PCF, ValidD, InstrD, BUB);
        end
        // redirect must beat StallF and a not-ready memory
        PCSrcW = 0; ALUResultE = 32'h200; StallF = 1; imem_ready = 0;
        cycle();
        idle_inputs();
        vectors++;
        if ({PCF, ValidD} !== {32'h200, 1'b0}) begin
            miscompares++;
            $display("FAIL redirect_over_stall: got pc=%h v=%b want 200/0", PCF, ValidD);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        StallF = 1; StallD = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if ({PCF, InstrD, PCD, ValidD} !== {32'd16, mem_word(32'd12), 32'd12, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got pc=%h instr=%h pcd=%h v=%b want 10/%h/c/1",
                         i, PCF, InstrD, PCD, ValidD, mem_word(32'd12));
            end
        end
        StallF = 0; StallD = 0; FlushD = 1;
        cycle();
        vectors++;
        if ({ValidD, InstrD, PCD, PCF} !== {1'b0, BUB, 32'h0, 32'd20}) begin
            miscompares++;
            $display("FAIL flush_bubble: got v=%b instr=%h pcd=%h pc=%h want 0/%h/0/14", ValidD, InstrD, PCD, PCF, BUB);
        end
        FlushD = 0;
        cycle();
        FlushD = 1; StallD = 1; StallF = 1;
        cycle();
        idle_inputs();
        vectors++;
        if ({ValidD, InstrD, PCF} !== {1'b0, BUB, 32'd24}) begin
            miscompares++;
            $display("FAIL flush_beats_stall: got v=%b instr=%h pc=%h want 0/%h/18", ValidD, InstrD, PCF, BUB);
        end
    endtask

    task automatic test_imem_wait();
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if ({PCF, ValidD, InstrD} !== {32'd20, 1'b0, BUB}) begin
                miscompares++;
                $display("FAIL imem_wait[%0d]: got pc=%h v=%b instr=%h want 14/0/%h", i, PCF, ValidD, InstrD, BUB);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, stall_cnt, flush_cnt} !== {32'd5, 32'd3, 32'd0}) begin
            miscompares++;
            $display("FAIL imem_wait_counters: got f=%0d s=%0d fl=%0d want 5/3/0", fetch_cnt, stall_cnt, flush_cnt);
        end
`endif
        imem_ready = 1;
        cycle();
        vectors++;
        if ({PCD, ValidD, PCF} !== {32'd20, 1'b1, 32'd24}) begin
            miscompares++;
            $display("FAIL imem_resume: got pcd=%h v=%b pc=%h want 14/1/18", PCD, ValidD, PCF);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        BranchTakenE = 1; ALUResultE = 32'hFFFF_FFFC;
        cycle();
        BranchTakenE = 0;
        cycle();
        vectors++;
        if ({PCF, PCD, PCPlus8D, InstrD} !== {32'h0, 32'hFFFF_FFFC, 32'h4, mem_word(32'hFFFF_FFFC)}) begin
            miscompares++;
            $display("FAIL pc_wrap: got pc=%h pcd=%h p8=%h instr=%h want 0/fffffffc/4/%h",
                     PCF, PCD, PCPlus8D, InstrD, mem_word(32'hFFFF_FFFC));
        end
        BranchTakenE = 1; ALUResultE = 32'hFFFF_FFFC;
        cycle();
        cycle();
        BranchTakenE = 0;
        // PCF=FFFFFFFC, PCD=FFFFFFFC is not possible simultaneously; PCF is at target now
        #2;
        reset = 1;
        #1;
        vectors++;
        if ({PCF, InstrD, ValidD, PCD, PCPlus8D} !== {32'h0, BUB, 1'b0, 32'h0, 32'h8}) begin
            miscompares++;
            $display("FAIL async_reset: got pc=%h instr=%h v=%b pcd=%h p8=%h want 0/%h/0/0/8",
                     PCF, InstrD, ValidD, PCD, PCPlus8D, BUB);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin
            miscompares++;
            $display("FAIL async_reset_counters: got %h %h %h want 0", fetch_cnt, stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        reset = 0;
        model_reset();
        cycle();
        vectors++;
        if ({PCF, PCD, ValidD} !== {32'h4, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL first_fetch_after_reset: got pc=%h pcd=%h v=%b want 4/0/1", PCF, PCD, ValidD);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            StallF       = ($urandom % 6) == 0;
            StallD       = ($urandom % 6) == 0;
            FlushD       = ($urandom % 10) == 0;
            BranchTakenE = ($urandom % 8) == 0;
            PCSrcW       = ($urandom % 16) == 0;
            imem_ready   = ($urandom % 5) != 0;
            ALUResultE   = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + 32'(4 * ($urandom % 4)))
                                               : ($urandom & 32'hFFFF_FFFC);
            ResultW      = $urandom & 32'hFFFF_FFFC;
            cycle();
            vectors++;
            if ({PCF, imem_addr, InstrD, ValidD, PCD, PCPlus8D} !==
                {m_pc, m_pc, m_instr, m_valid, m_pcd, m_pcd + 32'd8}) begin
                miscompares++;
                $display("FAIL random[%0d]: got pc=%h addr=%h instr=%h v=%b pcd=%h p8=%h want pc=%h instr=%h v=%b pcd=%h",
                         i, PCF, imem_addr, InstrD, ValidD, PCD, PCPlus8D, m_pc, m_instr, m_valid, m_pcd);
            end
`ifdef FETCH_PERF_CNT_EN
            vectors++;
            if ({fetch_cnt, stall_cnt, flush_cnt} !== {m_fetch, m_stall, m_flush}) begin
                miscompares++;
                $display("FAIL random_counters[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, fetch_cnt, stall_cnt, flush_cnt, m_fetch, m_stall, m_flush);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 0;
        idle_inputs();
        model_reset();
        #2;
        test_reset();
        test_sequential();
        test_branch();
        test_wb_priority();
        test_stall_flush();
        test_imem_wait();
        test_wrap_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined ARM core. It sits directly upstream of the controller and decode datapath. It owns the program counter and presents the instruction memory address. It applies branch and PC-write redirects from execute and writeback, honours stall and flush requests from the hazard unit, and delivers the decode-stage instruction bus with its PC values.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `BUBBLE_INSTR`, default 32'h0000_0000: value driven on `InstrD` when decode holds a bubble.
- `clk`  in  1: core clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `StallF`  in  1: hold PC (hazard unit).
- `StallD`  in  1: hold IF/ID register.
- `FlushD`  in  1: load a bubble into IF/ID.
- `BranchTakenE`  in  1: branch resolved taken in execute.
- `ALUResultE`  in  32: branch target accompanying `BranchTakenE`.
- `PCSrcW`  in  1: PC written by an instruction in writeback.
- `ResultW`  in  32: new PC accompanying `PCSrcW`.
- `imem_addr`  out  32: instruction address; equals `PCF`.
- `imem_rdata`  in  32: instruction word for `imem_addr`.
- `imem_ready`  in  1: `imem_rdata` valid this cycle.
- `PCF`  out  32: current fetch PC.
- `InstrD`  out  32: decode-stage instruction; this is the controller's `inst_bus`.
- `ValidD`  out  1: `InstrD` is a real instruction, not a bubble.
- `PCD`  out  32: PC of `InstrD`.
- `PCPlus8D`  out  32: `PCD + 8`; the R15 read value for decode.
- `fetch_cnt`, `stall_cnt`, `flush_cnt`  out  32 each: present only with `FETCH_PERF_CNT_EN`.

## Operation
- Next-PC priority, highest first:
  - `reset`: load `RESET_PC`.
  - `PCSrcW`: load `ResultW`.
  - `BranchTakenE`: load `ALUResultE`.
  - `StallF`: hold.
  - `!imem_ready`: hold.
  - Otherwise: load `PCF + 4`.
- All PC arithmetic is modulo 2^32. `PCF = 32'hFFFF_FFFC` advances to `32'h0000_0000`.
- A redirect (`PCSrcW` or `BranchTakenE`) overrides `StallF` and `imem_ready`. No fetch is accepted in a redirect cycle.
- IF/ID register priority, highest first:
  - `reset`: bubble, i.e. `InstrD=BUBBLE_INSTR`, `ValidD=0`, `PCD=0`.
  - `FlushD`: bubble.
  - `StallD`: hold all fields.
  - Redirect this cycle: bubble. The wrong-path word is discarded.
  - `!imem_ready`: bubble.
  - Otherwise: load `imem_rdata`, `ValidD=1`, `PCD=PCF`.
- `StallF=1` with `StallD=0` while `imem_ready=1`: the instruction is passed to decode and the PC is held. The hazard unit never requests this, and the block does not check for it.
- The hazard unit never asserts `FlushD` and `StallD` together. If it does, `FlushD` wins.
- `PCPlus8D` is combinational from `PCD`.

## Timing
- All outputs are registered except `imem_addr` (equal to `PCF`) and `PCPlus8D`.
- Reset values:
  - `PCF=RESET_PC`.
  - `InstrD=BUBBLE_INSTR`, `ValidD=0`, `PCD=0`, `PCPlus8D=8`.
  - Counters 0.
- Fetch-to-decode latency is 1 cycle: the word accepted at edge n appears on `InstrD` after edge n.
- Redirect latency is 1 cycle. `BranchTakenE` high before edge n gives `PCF=ALUResultE` after edge n and a bubble in decode after edge n.
- `imem_ready` is sampled at the edge. The address is held stable while `imem_ready=0`, unless a redirect occurs.
- Reset deasserted mid-cycle: the first fetch is on the next rising edge with `PCF=RESET_PC`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: the three counters exist. All three wrap modulo 2^32 and are cleared by `reset`.
  - `fetch_cnt` increments on every accepted fetch, i.e. each edge where IF/ID loads with `ValidD=1`.
  - `stall_cnt` increments on every edge where the PC is held by `StallF` or `!imem_ready` with no redirect.
  - `flush_cnt` increments on every edge where IF/ID loads a bubble because of `FlushD` or a redirect.
- `FETCH_PERF_CNT_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset, then 4 cycles with `imem_ready=1` and no hazards -> `PCF` takes 0, 4, 8, 12. After the 4th edge `InstrD` holds the word from address 12, `PCD=12` and `PCPlus8D=20`.
- `BranchTakenE=1`, `ALUResultE=32'h100` for one cycle with `PCF=8` -> next `PCF=32'h100`, `ValidD=0`. The following cycle `PCD=32'h100`.
- `PCSrcW=1`, `ResultW=32'h40` together with `BranchTakenE=1`, `ALUResultE=32'h80` -> `PCF=32'h40` (writeback wins), and decode holds a bubble.
- `StallF=StallD=1` for 2 cycles at `PCF=16` -> `PCF` stays 16 and `InstrD`/`PCD` hold. Then `FlushD=1` alone -> `ValidD=0`, `InstrD=BUBBLE_INSTR`.
- `imem_ready=0` for 3 cycles at `PCF=20` -> `PCF` held at 20 and 3 bubbles enter decode. With `FETCH_PERF_CNT_EN`: `stall_cnt` rises by 3 and `fetch_cnt` is unchanged.
- Assert `reset` asynchronously mid-cycle while `PCF=32'hFFFF_FFFC` -> outputs go to reset values immediately, without waiting for an edge. Separately, without reset, `PCF=32'hFFFF_FFFC` advances to 0.
